load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-stage data-access engine for the pipelined RV32I core. It takes load/store requests from the execute-to-memory boundary, drives a variable-latency data-memory bus with a req/ack handshake, and performs RV32I byte-lane steering and load extension. It returns ReadDataM toward the memory-to-writeback pipeline register and produces StallM, which the hazard logic uses to deassert `en` on all pipeline registers while an access is in flight.

Parameters:
ADDR_WIDTH, 32, data-bus address width; upper bits of ALUResultM beyond this are ignored.
TIMEOUT_CYCLES, 16, ack wait limit (used only with LSU_TIMEOUT_EN); must be >= 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
MemReadM  input  1  load in memory stage.
MemWriteM  input  1  store in memory stage.
Funct3M  input  3  RV32I width/sign code.
ALUResultM  input  32  effective byte address.
WriteDataM  input  32  store data, rs2.
ReadDataM  output  32  extended load result, registered.
StallM  output  1  pipeline hold request, combinational from state/inputs.
MisalignM  output  1  one-cycle misaligned-access flag.
BusErrM  output  1  timeout flag (tied 0 without macro).
mem_req  output  1  bus request, registered.
mem_we  output  1  1 = write.
mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
mem_be  output  4  byte enables.
mem_wdata  output  32  lane-steered store data.
mem_ack  input  1  bus completion; rdata valid the same cycle.
mem_rdata  input  32  read word.

Behaviour:
- Reset (rst low, asynchronous) forces IDLE and clears all outputs, including ReadDataM, mem_req, mem_addr, mem_be, mem_wdata, MisalignM and BusErrM. A reset mid-access drops mem_req immediately; the pending transaction is abandoned.
- Access = MemReadM | MemWriteM. If both are asserted, the access is treated as a load.
- Width from Funct3M[1:0]:
  - 00 = byte.
  - 01 = half; misaligned if addr[0] = 1.
  - 1x = word; misaligned if addr[1:0] != 0.
  - Funct3M[2] = 1 selects zero-extension for loads.
  - Codes 011, 110 and 111 are handled as word.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned access: latch mem_we, mem_addr, mem_be and mem_wdata; set mem_req <= 1; go to BUSY. StallM = 1.
  - IDLE, misaligned access: no bus activity; MisalignM = 1 next cycle; ReadDataM <= 0; StallM = 0; stay in IDLE.
  - IDLE, no access: StallM = 0.
  - BUSY: StallM = 1; mem_req and all bus outputs are held stable until mem_ack.
  - BUSY, on mem_ack: mem_req <= 0. For a load, ReadDataM <= extend(lane(mem_rdata)); a store leaves ReadDataM unchanged. Go to DONE.
  - DONE: StallM = 0 so the pipeline advances exactly one edge; then go to IDLE unconditionally. A new access is first seen in IDLE.
- Latency: minimum 2 stall cycles (ack in the first BUSY cycle); total stall = 1 + number of BUSY cycles.
- Store steering:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: be = 1111.
- Load lanes: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]); sign-extended or zero-extended to 32 bits.
- For reads, mem_be = 1111 and mem_wdata = 0.
- mem_ack is ignored outside BUSY.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYCLES without mem_ack:
  - mem_req <= 0; BusErrM pulses for one cycle (DONE cycle).
  - A load yields ReadDataM <= 0.
  - Go to DONE.
  - If the ack arrives in the same cycle as the limit, the ack wins.
- Undefined: no counter exists, BUSY waits indefinitely, and BusErrM is tied 0.

Decomposition:
- Shared package: enum lsu_state_t {IDLE, BUSY, DONE}; Funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One combinational sub-module, lsu_lane_align: store steering, load extraction/extension and misalignment detection. The FSM lives in the top.

Test Plan:
- Load (LW) at addr 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> StallM high 4 cycles, mem_addr 0x100, ReadDataM 0xDEADBEEF in DONE.
- LB at 0x203, rdata 0x80FF1234 -> ReadDataM 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x302, WriteDataM 0x0000ABCD, ack in the first BUSY cycle -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, StallM 2 cycles.
- LW at 0x101 -> no mem_req, MisalignM pulse, StallM 0, ReadDataM 0.
- rst driven low in the second BUSY cycle -> mem_req 0 immediately, IDLE after release, no ReadDataM update.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> BusErrM pulse after 4 BUSY cycles, ReadDataM 0, StallM released.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared types and constants for the RV32I load/store unit:
//   lsu_state_t  - FSM states of the bus engine (IDLE, BUSY, DONE)
//   F3_*         - RV32I Funct3 width/sign codes for loads and stores
//   lsu_size_t   - decoded access size
//   size_of()    - Funct3 -> access size. Codes 011, 110 and 111 decode as word.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  // Bit 1 set means word regardless of bit 0, which folds 011/110/111 into word.
  function automatic lsu_size_t size_of(input logic [2:0] funct3);
    if (funct3[1]) return SZ_WORD;
    if (funct3[0]) return SZ_HALF;
    return SZ_BYTE;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane logic for the load/store unit.
//   Request side (current instruction):
//     funct3, addr_lo, is_load, store_data -> misalign, be, wdata
//     Stores: SB/SH byte enables shifted by the address, data replicated
//     across the word. Loads: be = 1111 and wdata = 0.
//   Response side (latched instruction):
//     ld_funct3, ld_addr_lo, rdata -> load_data
//     Selects the byte/half lane and sign- or zero-extends it to 32 bits.
// -----------------------------------------------------------------------------
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_load,
  input  logic [31:0] store_data,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  lsu_size_t   req_size;
  lsu_size_t   ld_size;
  logic [31:0] byte_lane;
  logic [31:0] half_lane;

  assign req_size = size_of(funct3);
  assign ld_size  = size_of(ld_funct3);

  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise an untaken path implies storage and synthesis infers a latch.
  always_comb begin
    misalign = 1'b0;
    be       = 4'b1111;
    wdata    = '0;

    unique case (req_size)
      SZ_HALF: misalign = addr_lo[0];
      SZ_WORD: misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase

    if (!is_load) begin
      unique case (req_size)
        SZ_BYTE: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SZ_HALF: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  assign byte_lane = rdata >> {ld_addr_lo, 3'b000};
  assign half_lane = rdata >> {ld_addr_lo[1], 4'b0000};

  // Funct3[2] selects zero-extension; it is irrelevant for word loads.
  always_comb begin
    load_data = rdata;
    unique case (ld_size)
      SZ_BYTE: load_data = ld_funct3[2] ? {24'h0, byte_lane[7:0]}
                                        : {{24{byte_lane[7]}}, byte_lane[7:0]};
      SZ_HALF: load_data = ld_funct3[2] ? {16'h0, half_lane[15:0]}
                                        : {{16{half_lane[15]}}, half_lane[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage data-access engine of the pipelined RV32I core. Drives a
// variable-latency req/ack data bus and returns the extended load result.
// Optional ack timeout: define LSU_TIMEOUT_EN.
//
// Parameters
//   ADDR_WIDTH     data-bus address width (upper ALUResultM bits ignored)
//   TIMEOUT_CYCLES ack wait limit in BUSY cycles (LSU_TIMEOUT_EN only), >= 2
// Ports
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   MemReadM/WriteM  load / store in memory stage (both set -> load)
//   Funct3M          RV32I width/sign code
//   ALUResultM       effective byte address
//   WriteDataM       store data (rs2)
//   ReadDataM        extended load result, registered
//   StallM           pipeline hold request, combinational
//   MisalignM        one-cycle misaligned-access flag
//   BusErrM          one-cycle timeout flag (0 without LSU_TIMEOUT_EN)
//   mem_req/we/addr/be/wdata  registered bus request, held until mem_ack
//   mem_ack, mem_rdata        bus completion, read data valid with ack
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [31:0]           ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be >= 2");
  end

  lsu_state_t  state, state_next;
  logic        access;
  logic        is_load;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        timeout;
  // Width code and lane of the access in flight, needed when the ack returns.
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;

  assign access  = MemReadM | MemWriteM;
  assign is_load = MemReadM;

  lsu_lane_align u_lane_align (
    .funct3     (Funct3M),
    .addr_lo    (ALUResultM[1:0]),
    .is_load    (is_load),
    .store_data (WriteDataM),
    .misalign   (misalign),
    .be         (be),
    .wdata      (wdata),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .rdata      (mem_rdata),
    .load_data  (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;

  // Zero outside BUSY, so every access starts counting from 0; the last
  // BUSY cycle before timeout is the one where the count is LIMIT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != BUSY) begin
      wait_cnt <= '0;
    end else if (!timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE releases the stall for exactly one edge; new accesses only in IDLE.
  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && !misalign) begin
          state_next = BUSY;
          StallM     = 1'b1;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (mem_ack || timeout) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ReadDataM  <= '0;
      MisalignM  <= 1'b0;
      BusErrM    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      ld_funct3  <= '0;
      ld_addr_lo <= '0;
    end else begin
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access && misalign) begin
            MisalignM <= 1'b1;
            ReadDataM <= '0;
          end else if (access) begin
            mem_req    <= 1'b1;
            mem_we     <= !is_load;
            mem_addr   <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
            mem_be     <= be;
            mem_wdata  <= wdata;
            ld_funct3  <= Funct3M;
            ld_addr_lo <= ALUResultM[1:0];
          end
        end
        BUSY: begin
          // An ack in the limit cycle takes priority over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadDataM <= load_data;
          end else if (timeout) begin
            mem_req <= 1'b0;
            BusErrM <= 1'b1;
            if (!mem_we) ReadDataM <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
